// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: sole driver of the register file write port, merging
// unstallable pipeline results with buffered long-latency results drained into idle slots.
module regfile_writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_we,
   input  logic [ADDR_WIDTH-1:0] pipe_rd,
   input  logic [DATA_WIDTH-1:0] pipe_wd,
   input  logic                  lu_issue,
   input  logic [ADDR_WIDTH-1:0] lu_issue_rd,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [ADDR_WIDTH-1:0] lu_rd,
   input  logic [DATA_WIDTH-1:0] lu_wd,
   output logic                  WE3,
   output logic [ADDR_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0] WD3,
   output logic [31:0]           pending_mask,
   output logic                  stall_req
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LP_FULL  = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] LP_LIMIT = SW'(STARVE_LIMIT);

   logic [ADDR_WIDTH-1:0] r_fifo_rd [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_wd [FIFO_DEPTH];
   logic [PW-1:0]         r_rptr, r_wptr;
   logic [CW-1:0]         r_count;
   logic [SW-1:0]         r_starve;
   logic                  w_pipe_slot, w_push, w_pop;
   logic [ADDR_WIDTH-1:0] w_head_rd;
   logic [DATA_WIDTH-1:0] w_head_wd;
   logic [31:0]           w_set, w_clr;
   logic [SW-1:0]         w_starve_nxt;

   assign lu_ready = r_count < LP_FULL;

   always_comb begin
      w_pipe_slot  = pipe_we && pipe_rd != '0;
      w_push       = lu_valid && lu_ready && lu_rd != '0;
      w_pop        = !w_pipe_slot && r_count != '0;
      w_head_rd    = r_fifo_rd[r_rptr];
      w_head_wd    = r_fifo_wd[r_rptr];
      w_set        = (lu_issue && lu_issue_rd != '0) ? 32'd1 << lu_issue_rd : '0;
      w_clr        = w_pop ? 32'd1 << w_head_rd : '0;
      // counter saturates at the limit so it can never wrap and drop stall_req spuriously
      w_starve_nxt = (w_pop || r_count != LP_FULL || !w_pipe_slot) ? '0 :
                     (r_starve == LP_LIMIT) ? r_starve : r_starve + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr] <= lu_rd;
         r_fifo_wd[r_wptr] <= lu_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rptr       <= '0;
         r_wptr       <= '0;
         r_count      <= '0;
         r_starve     <= '0;
         WE3          <= 1'b0;
         A3           <= '0;
         WD3          <= '0;
         pending_mask <= '0;
         stall_req    <= 1'b0;
      end else begin
         WE3          <= w_pipe_slot || w_pop;
         A3           <= w_pipe_slot ? pipe_rd : w_pop ? w_head_rd : A3;
         WD3          <= w_pipe_slot ? pipe_wd : w_pop ? w_head_wd : WD3;
         r_rptr       <= r_rptr + PW'(w_pop);
         r_wptr       <= r_wptr + PW'(w_push);
         r_count      <= r_count + CW'(w_push) - CW'(w_pop);
         pending_mask <= (pending_mask & ~w_clr) | w_set;
         r_starve     <= w_starve_nxt;
         stall_req    <= w_starve_nxt >= LP_LIMIT;
      end
   end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed and random stimulus checked through a per-cycle
// scoreboard fed by a queue-based reference model of the write port.
module tb_regfile_writeback_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, pipe_we, lu_issue, lu_valid, lu_ready, WE3, stall_req;
   logic [4:0]  pipe_rd, lu_issue_rd, lu_rd, A3;
   logic [31:0] pipe_wd, lu_wd, WD3, pending_mask;

   regfile_writeback_arbiter dut (
      .clk(clk), .rst_n(rst_n), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
      .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .lu_valid(lu_valid), .lu_ready(lu_ready),
      .lu_rd(lu_rd), .lu_wd(lu_wd), .WE3(WE3), .A3(A3), .WD3(WD3),
      .pending_mask(pending_mask), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic        rdy;
      logic [31:0] pend;
      logic        stall;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;

   exp_t        exp_q[$];
   ent_t        m_q[$];
   logic [31:0] m_pend;
   logic [4:0]  m_a;
   logic [31:0] m_d;
   int          m_starve;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("WE3", 32'(WE3), 32'(e.we));
         chk("A3", 32'(A3), 32'(e.a));
         chk("WD3", WD3, e.d);
         chk("lu_ready", 32'(lu_ready), 32'(e.rdy));
         chk("pending_mask", pending_mask, e.pend);
         chk("stall_req", 32'(stall_req), 32'(e.stall));
      end
   end

   // Reference: long results are a plain queue; the pipeline owns any slot it claims.
   task automatic step(input logic rst, input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic iss, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
      exp_t e;
      ent_t h;
      bit   slot, pop, full;
      rst_n = rst; pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
      lu_issue = iss; lu_issue_rd = ird; lu_valid = lv; lu_rd = lrd; lu_wd = lwd;
      e.we = 1'b0;
      if (!rst) begin
         m_q.delete(); m_pend = '0; m_starve = 0; m_a = '0; m_d = '0;
      end else begin
         slot = pwe && prd != 0;
         full = m_q.size() >= 2;
         pop  = !slot && m_q.size() > 0;
         if (slot) begin
            e.we = 1'b1; m_a = prd; m_d = pwd;
         end else if (pop) begin
            h = m_q.pop_front();
            e.we = 1'b1; m_a = h.rd; m_d = h.wd; m_pend[h.rd] = 1'b0;
         end
         if (lv && !full && lrd != 0) m_q.push_back('{lrd, lwd});
         if (iss && ird != 0) m_pend[ird] = 1'b1;
         m_starve = (full && slot && !pop) ? m_starve + 1 : 0;
      end
      e.a = m_a; e.d = m_d; e.rdy = m_q.size() < 2; e.pend = m_pend; e.stall = m_starve >= 4;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      m_pend = '0; m_a = '0; m_d = '0; m_starve = 0;
      for (int i = 0; i < 3; i++) step(0, 1, 5'd5, 32'h1111_1111, 0, 0, 0, 0, 0);
      step(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      step(1, 1, 5'd0, 32'h0BAD_0BAD, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 5'd7, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1234);
      idle(3);
      step(1, 1, 5'd1, 32'hA, 1, 5'd3, 1, 5'd3, 32'h3333);
      step(1, 1, 5'd2, 32'hB, 1, 5'd4, 1, 5'd4, 32'h4444);
      for (int i = 0; i < 6; i++) step(1, 1, 5'(i + 10), 32'(i), 0, 0, 1, 5'd6, 32'h6666);
      idle(3);
      step(1, 1, 5'd1, 32'hC, 1, 5'd9, 1, 5'd9, 32'h9999);
      step(1, 0, 0, 0, 0, 0, 1, 5'd8, 32'h8888);
      step(1, 0, 0, 0, 1, 5'd9, 0, 0, 0);
      idle(2);
      step(1, 1, 5'd1, 32'hD, 0, 0, 1, 5'd11, 32'hB1);
      step(1, 1, 5'd2, 32'hE, 0, 0, 1, 5'd12, 32'hB2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF);
      idle(2);
      for (int i = 0; i < 600; i++) begin
         logic pwe;
         pwe = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 85 : 35));
         step($urandom_range(0, 199) != 0, pwe, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      end
      idle(4);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
